// File: rtl/mux2k_lut_reg.sv
// mux2k_lut_reg: 2^SEL_BITS-input mux split into 1/2/4 groups, each output combinational or registered.
// Latency: 0 cycles combinational, 1 cycle registered; `MUXLUT_PIPE_EN adds an input stage (+1 cycle).
// Backpressure: none; CE stalls the registers, SR loads SR_INIT and overrides CE.
module mux2k_lut_reg #(
   parameter int SEL_BITS     = 3,
   parameter int NoConfigBits = 4
) (
   input  logic                     UserCLK,
   input  logic                     resetn,
   input  logic [(1<<SEL_BITS)-1:0] I,
   input  logic [SEL_BITS-1:0]      S,
   input  logic                     CE,
   input  logic                     SR,
   output logic [3:0]               M,
   input  logic [NoConfigBits-1:0]  ConfigBits
);
   localparam int N = 1 << SEL_BITS;
   // Largest split that still leaves at least one select bit per group.
   localparam logic [1:0] MODE_MAX = (SEL_BITS > 2) ? 2'd2 : 2'd1;

   logic [1:0]          mode_raw;
   logic [1:0]          m_eff;
   logic                reg_en;
   logic                sr_init;
   logic [3:0]          act;
   logic [2:0]          grp_shift;
   logic [SEL_BITS-1:0] lo_mask;
   logic [N-1:0]        i_mux;
   logic [SEL_BITS-1:0] s_mux;
   logic [3:0]          mux_val;
   logic [3:0]          r_q;

   assign mode_raw = ConfigBits[1:0];
   assign reg_en   = ConfigBits[2];
   assign sr_init  = ConfigBits[3];
   assign m_eff    = (mode_raw > MODE_MAX) ? MODE_MAX : mode_raw;

   always_comb begin
      act = 4'b0001;
      case (m_eff)
         2'd0:    act = 4'b0001;
         2'd1:    act = 4'b0011;
         default: act = 4'b1111;
      endcase
   end

`ifdef MUXLUT_PIPE_EN
   logic [N-1:0]        i_q;
   logic [SEL_BITS-1:0] s_q;

   always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
         i_q <= '0;
         s_q <= '0;
      end else if (CE) begin
         i_q <= I;
         s_q <= S;
      end
   end

   assign i_mux = i_q;
   assign s_mux = s_q;
`else
   assign i_mux = I;
   assign s_mux = S;
`endif

   // Group g owns slice I[g*L +: L]; low select bits pick within it, upper ones drop out.
   assign grp_shift = 3'(SEL_BITS) - {1'b0, m_eff};
   assign lo_mask   = {SEL_BITS{1'b1}} >> m_eff;

   for (genvar g = 0; g < 4; g++) begin : g_grp
      logic [SEL_BITS-1:0] idx;
      assign idx        = (SEL_BITS'(g) << grp_shift) | (s_mux & lo_mask);
      assign mux_val[g] = act[g] & i_mux[idx];
   end

   always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
         r_q <= '0;
      end else if (SR) begin
         r_q <= {4{sr_init}} & act;
      end else if (CE) begin
         r_q <= mux_val;
      end
   end

   // Masking on the output keeps stale register bits hidden after a mode change.
   assign M = reg_en ? (r_q & act) : mux_val;

endmodule

// File: tb/tb_mux2k_lut_reg.sv
// Bench for mux2k_lut_reg: K=3 and K=4 instances, reference model plus directed literal checks.
module tb_mux2k_lut_reg;
`ifdef MUXLUT_PIPE_EN
   localparam int PIPE = 1;
`else
   localparam int PIPE = 0;
`endif

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;

   logic [7:0]  i3   = '0;
   logic [2:0]  s3   = '0;
   logic        ce3  = 1'b0;
   logic        sr3  = 1'b0;
   logic [3:0]  cfg3 = 4'b0100;
   logic [3:0]  m3;

   logic [15:0] i4   = '0;
   logic [3:0]  s4   = '0;
   logic        ce4  = 1'b0;
   logic        sr4  = 1'b0;
   logic [3:0]  cfg4 = 4'b0100;
   logic [3:0]  m4;

   int tests = 0;
   int fails = 0;

   // model state
   logic [3:0]  r3_ref = '0, r4_ref = '0;
   logic [7:0]  ip3 = '0;
   logic [2:0]  sp3 = '0;
   logic [15:0] ip4 = '0;
   logic [3:0]  sp4 = '0;

   always #5 clk = ~clk;

   mux2k_lut_reg #(.SEL_BITS(3), .NoConfigBits(4)) dut3 (
      .UserCLK(clk), .resetn(rst_n), .I(i3), .S(s3), .CE(ce3), .SR(sr3),
      .M(m3), .ConfigBits(cfg3)
   );

   mux2k_lut_reg #(.SEL_BITS(4), .NoConfigBits(4)) dut4 (
      .UserCLK(clk), .resetn(rst_n), .I(i4), .S(s4), .CE(ce4), .SR(sr4),
      .M(m4), .ConfigBits(cfg4)
   );

   function automatic int split(input int k, input logic [1:0] mode);
      int m;
      m = int'(mode);
      if (m > 2) m = 2;
      if (m > k - 1) m = k - 1;
      return m;
   endfunction

   function automatic logic [3:0] act_ref(input int k, input logic [1:0] mode);
      logic [3:0] a;
      a = '0;
      for (int g = 0; g < (1 << split(k, mode)); g++) a[g] = 1'b1;
      return a;
   endfunction

   function automatic logic [3:0] mux_ref(input int k, input logic [15:0] i,
                                          input logic [3:0] s, input logic [1:0] mode);
      int n, gc, l;
      logic [3:0] r;
      n  = 1 << k;
      gc = 1 << split(k, mode);
      l  = n / gc;
      r  = '0;
      for (int g = 0; g < gc; g++) r[g] = i[g * l + (int'(s) % l)];
      return r;
   endfunction

   function automatic logic [3:0] exp3();
      logic [15:0] mi;
      logic [3:0]  ms;
      mi = (PIPE != 0) ? {8'h00, ip3} : {8'h00, i3};
      ms = (PIPE != 0) ? {1'b0, sp3} : {1'b0, s3};
      return cfg3[2] ? (r3_ref & act_ref(3, cfg3[1:0])) : mux_ref(3, mi, ms, cfg3[1:0]);
   endfunction

   function automatic logic [3:0] exp4();
      logic [15:0] mi;
      logic [3:0]  ms;
      mi = (PIPE != 0) ? ip4 : i4;
      ms = (PIPE != 0) ? sp4 : s4;
      return cfg4[2] ? (r4_ref & act_ref(4, cfg4[1:0])) : mux_ref(4, mi, ms, cfg4[1:0]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r3_ref <= '0; ip3 <= '0; sp3 <= '0;
         r4_ref <= '0; ip4 <= '0; sp4 <= '0;
      end else begin
         if (ce3) begin ip3 <= i3; sp3 <= s3; end
         if (ce4) begin ip4 <= i4; sp4 <= s4; end
         if (sr3)
            r3_ref <= {4{cfg3[3]}} & act_ref(3, cfg3[1:0]);
         else if (ce3)
            r3_ref <= mux_ref(3, (PIPE != 0) ? {8'h00, ip3} : {8'h00, i3},
                              (PIPE != 0) ? {1'b0, sp3} : {1'b0, s3}, cfg3[1:0]);
         if (sr4)
            r4_ref <= {4{cfg4[3]}} & act_ref(4, cfg4[1:0]);
         else if (ce4)
            r4_ref <= mux_ref(4, (PIPE != 0) ? ip4 : i4, (PIPE != 0) ? sp4 : s4, cfg4[1:0]);
      end
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_k3", m3, exp3());
      check("model_k4", m4, exp4());
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #1 check("reset_m3", m3, 4'b0000);
      check("reset_m4", m4, 4'b0000);
      #10 rst_n = 1'b1;
      tick();

      // one-hot sweep, single group, combinational
      cfg3 = 4'b0000; i3 = 8'h80; ce3 = 1'b1;
      for (int s = 0; s < 8; s++) begin
         s3 = 3'(s);
         repeat (PIPE) tick();
         #1 check("sweep", m3, (s == 7) ? 4'b0001 : 4'b0000);
      end

      // four groups, upper select bit ignored
      cfg3 = 4'b0010; i3 = 8'b1001_1100; s3 = 3'b001;
      repeat (PIPE) tick();
      #1 check("split4", m3, 4'b1010);
      s3 = 3'b101;
      repeat (PIPE) tick();
      #1 check("split4_upper", m3, 4'b1010);

      // registered two-group capture then CE hold
      tick();
      rst_n = 1'b0;
      cfg3 = 4'b0101; i3 = 8'hF0; s3 = 3'b000; ce3 = 1'b1; sr3 = 1'b0;
      #1 check("reg_reset", m3, 4'b0000);
      rst_n = 1'b1;
      repeat (1 + PIPE) tick();
      check("reg_capture", m3, 4'b0010);
      ce3 = 1'b0; i3 = 8'h0F;
      repeat (3) begin
         tick();
         check("ce_hold", m3, 4'b0010);
      end

      // SR beats CE; async reset between edges
      cfg3 = 4'b1110; sr3 = 1'b1; ce3 = 1'b1;
      tick();
      check("sr_set", m3, 4'b1111);
      sr3 = 1'b0; ce3 = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("async_reset", m3, 4'b0000);
      rst_n = 1'b1;
      tick();
      sr3 = 1'b1; ce3 = 1'b1;
      tick();
      check("sr_set2", m3, 4'b1111);
      cfg3 = 4'b0110; i3 = 8'hFF;
      tick();
      check("sr_init0", m3, 4'b0000);
      sr3 = 1'b0;

      // K=4, MODE 3 saturates to four groups of four
      cfg4 = 4'b0111; i4 = 16'hA5C3; s4 = 4'b0010; ce4 = 1'b1;
      repeat (1 + PIPE) tick();
      check("k4_sat_a", m4, 4'b0110);
      s4 = 4'b1101;
      repeat (1 + PIPE) tick();
      check("k4_sat_b", m4, 4'b1001);
      cfg4 = 4'b0100;
      #1 check("k4_mode0_mask", m4, 4'b0001);
      cfg4 = 4'b0011;
      #1 check("k4_comb", m4, 4'b1001);

      // step response latency
      cfg3 = 4'b0100; s3 = 3'b000; i3 = 8'h00; ce3 = 1'b1;
      repeat (2) tick();
      i3 = 8'hFF;
      repeat (PIPE) tick();
      check("reg_step_pre", m3, 4'b0000);
      tick();
      check("reg_step_rise", m3, 4'b0001);
      cfg3 = 4'b0000; i3 = 8'h00;
      repeat (2) tick();
      i3 = 8'hFF;
      #1 check("comb_step_pre", m3, (PIPE != 0) ? 4'b0000 : 4'b0001);
      repeat (PIPE) tick();
      check("comb_step_rise", m3, 4'b0001);

      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
